uart_rx_pkt_ctrl: RTL and testbench
===================================

// Module: uart_rx_pkt_ctrl
// PURPOSE
//  Packet controller placed after the UART receiver. It consumes the receiver's byte stream
//  (one strobe per byte) and frames it as SYNC, LEN, payload[LEN] and optional checksum.
//  The payload goes into an internal buffer and is handed to one consumer with a valid/ack handshake.
//  Malformed, stalled and overrunning frames are rejected with single-cycle error pulses.
// PARAMETERS
//  MAX_LEN       16      max payload bytes (1..16); buffer depth
//  SYNC_BYTE     8'hA5   frame start marker
//  TIMEOUT_CLKS  260420  max idle clocks between bytes inside a frame (2 byte-times at 9600 baud)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  synchronous reset, active low
//  rx_data      in   8  received byte, valid when rx_ready=1
//  rx_ready     in   1  byte strobe; each high cycle counts as one byte
//  pkt_valid    out  1  complete packet held in buffer
//  pkt_ack      in   1  consumer releases the buffer
//  pkt_len      out  5  payload length of the held packet (1..MAX_LEN)
//  rd_addr      in   4  buffer read index
//  rd_data      out  8  buf[rd_addr], combinational; 8'h00 if rd_addr >= MAX_LEN
//  err_len      out  1  pulse: LEN byte is 0 or > MAX_LEN
//  err_chk      out  1  pulse: checksum mismatch
//  err_timeout  out  1  pulse: inter-byte gap exceeded inside a frame
//  err_overrun  out  1  pulse: byte arrived while packet held (byte dropped)
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - state=IDLE; all outputs 0; counters and buffer cleared.
//   - Reset mid-frame aborts the frame silently; no error pulse.
//  FSM states: IDLE, LEN, PAYLOAD, CHK, HOLD. All transitions are on an rx_ready cycle unless noted.
//   IDLE:    byte==SYNC_BYTE -> LEN, sum=0. Any other byte is ignored.
//   LEN:     byte in 1..MAX_LEN -> store as len, sum=byte, idx=0, go to PAYLOAD.
//            Otherwise pulse err_len and go to IDLE.
//   PAYLOAD: buf[idx]=byte, sum+=byte (mod 256), idx++.
//            After byte number len -> CHK (or HOLD when the macro is undefined).
//   CHK:     (sum+byte) mod 256 == 0 -> HOLD. Otherwise pulse err_chk and go to IDLE.
//   HOLD:    - pkt_valid=1 and pkt_len=len, both registered.
//            - pkt_valid rises the cycle after the last accepted byte's strobe.
//            - Buffer is frozen while in HOLD.
//            - pkt_ack=1 -> pkt_valid=0 on the next cycle, go to IDLE.
//            - rx_ready=1 -> byte dropped, err_overrun pulse.
//            - rx_ready and pkt_ack in the same cycle: both take effect (drop + pulse, then IDLE).
//  Timeout:
//   - Gap counter runs only in LEN, PAYLOAD and CHK; it clears on every rx_ready.
//   - Counter reaching TIMEOUT_CLKS-1 without rx_ready -> err_timeout pulse, go to IDLE.
//   - rx_ready in the expiry cycle wins: the byte is processed and no timeout occurs.
//  pkt_ack outside HOLD is ignored. Each error pulse is exactly one cycle; errors are mutually exclusive.
//  Buffer keeps the last packet after release; bytes from a rejected frame may overwrite it.
// CONFIGURATION
//  UART_PKT_CHECKSUM_EN
//   Defined:   CHK state present. The frame carries a trailing checksum byte with
//              (LEN + payload + CHK) mod 256 == 0.
//   Undefined: no CHK state and no checksum byte. HOLD is entered after the last payload byte;
//              err_chk is tied to 0.
// TESTING (checksum enabled unless noted)
//  1. A5 03 11 22 33 97 -> pkt_valid=1 1 clk after the 97 strobe; pkt_len=3; rd 0..2 = 11,22,33.
//     pkt_ack -> pkt_valid=0 next clk.
//  2. 00 FF A5 01 5A A5 -> A5 at LEN=1? No: 00/FF ignored; A5 01 5A A5 accepted
//     (sum 01+5A+A5=0x100); pkt_len=1, rd0=5A.
//  3. A5 00 and A5 11 (MAX_LEN=16) -> err_len pulse each, state IDLE, pkt_valid stays 0.
//  4. A5 02 10 20 00 -> err_chk one pulse; the following A5 02 10 20 CE is accepted.
//  5. A5 02 10, then no strobe for TIMEOUT_CLKS clocks -> err_timeout once, IDLE.
//     Strobe at the expiry cycle -> no timeout.
//  6. Packet held, send 3 bytes -> 3 err_overrun pulses, buffer unchanged.
//     rst_n low mid-PAYLOAD -> all outputs 0, no error pulse.
//     Macro undefined: A5 02 10 20 -> pkt_valid.

Source files
------------

// File: rtl/uart_rx_pkt_ctrl.sv
`timescale 1ns/1ps
// uart_rx_pkt_ctrl
// Purpose     : frames the UART receiver byte stream (SYNC, LEN, payload[LEN], optional
//               checksum) into a single packet buffer that is handed off with a valid/ack handshake.
// Latency     : pkt_valid rises 1 clk after the last accepted byte strobe. Error pulses appear
//               1 clk after the offending strobe or gap expiry.
// Backpressure: none towards the receiver. Bytes that arrive while a packet is held are
//               dropped and flagged with err_overrun.
//
// Build macro : UART_PKT_CHECKSUM_EN
//               defined   -> a trailing checksum byte is expected, with (LEN+payload+CHK) mod 256 == 0
//               undefined -> no checksum byte. HOLD follows the last payload byte and err_chk is tied 0.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rx_data/rx_ready  byte from the receiver; one byte per high cycle of rx_ready
//   pkt_valid/pkt_ack packet held / consumer releases it
//   pkt_len           payload length of the held packet (0 when nothing is held)
//   rd_addr/rd_data   combinational buffer read port (8'h00 beyond MAX_LEN)
//   err_len/err_chk/err_timeout/err_overrun   single-cycle, mutually exclusive error pulses
module uart_rx_pkt_ctrl #(
   parameter int unsigned MAX_LEN      = 16,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_CLKS = 260420
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   output logic       pkt_valid,
   input  logic       pkt_ack,
   output logic [4:0] pkt_len,
   input  logic [3:0] rd_addr,
   output logic [7:0] rd_data,
   output logic       err_len,
   output logic       err_chk,
   output logic       err_timeout,
   output logic       err_overrun
);

   localparam int GAP_W = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
`ifdef UART_PKT_CHECKSUM_EN
      S_CHK,
`endif
      S_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       len_q, len_d;
   logic [4:0]       idx_q, idx_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             wr_en;
   logic             err_len_q, err_len_d;
   logic             err_to_q, err_to_d;
   logic             err_ovr_q, err_ovr_d;
   logic             pkt_valid_q;
   logic [4:0]       pkt_len_q;
   logic [7:0]       buf_q [MAX_LEN];
`ifdef UART_PKT_CHECKSUM_EN
   logic [7:0]       sum_q, sum_d;
   logic             err_chk_q, err_chk_d;
`endif

   // Next-state / datapath control
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      idx_d     = idx_q;
      gap_d     = '0;
      wr_en     = 1'b0;
      err_len_d = 1'b0;
      err_to_d  = 1'b0;
      err_ovr_d = 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
      sum_d     = sum_q;
      err_chk_d = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (rx_ready && (rx_data == SYNC_BYTE)) begin
               state_d = S_LEN;
`ifdef UART_PKT_CHECKSUM_EN
               sum_d   = 8'h00;
`endif
            end
         end

         S_LEN: begin
            gap_d = rx_ready ? '0 : gap_q + 1'b1;
            if (rx_ready) begin
               if ((rx_data != 8'h00) && (rx_data <= 8'(MAX_LEN))) begin
                  len_d   = rx_data[4:0];
                  idx_d   = 5'd0;
                  state_d = S_PAYLOAD;
`ifdef UART_PKT_CHECKSUM_EN
                  sum_d   = rx_data;
`endif
               end else begin
                  err_len_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end else if (gap_q == GAP_LAST) begin
               err_to_d = 1'b1;
               state_d  = S_IDLE;
            end
         end

         S_PAYLOAD: begin
            gap_d = rx_ready ? '0 : gap_q + 1'b1;
            if (rx_ready) begin
               wr_en = 1'b1;
               idx_d = idx_q + 5'd1;
`ifdef UART_PKT_CHECKSUM_EN
               sum_d = sum_q + rx_data;
`endif
               if (idx_q == len_q - 5'd1) begin
`ifdef UART_PKT_CHECKSUM_EN
                  state_d = S_CHK;
`else
                  state_d = S_HOLD;
`endif
               end
            end else if (gap_q == GAP_LAST) begin
               err_to_d = 1'b1;
               state_d  = S_IDLE;
            end
         end

`ifdef UART_PKT_CHECKSUM_EN
         S_CHK: begin
            gap_d = rx_ready ? '0 : gap_q + 1'b1;
            if (rx_ready) begin
               if ((sum_q + rx_data) == 8'h00) begin
                  state_d = S_HOLD;
               end else begin
                  err_chk_d = 1'b1;
                  state_d   = S_IDLE;
               end
            end else if (gap_q == GAP_LAST) begin
               err_to_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
`endif

         S_HOLD: begin
            // A drop and a release in the same cycle both take effect.
            err_ovr_d = rx_ready;
            if (pkt_ack) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         gap_q       <= '0;
         err_len_q   <= 1'b0;
         err_to_q    <= 1'b0;
         err_ovr_q   <= 1'b0;
         pkt_valid_q <= 1'b0;
         pkt_len_q   <= '0;
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            buf_q[i] <= 8'h00;
         end
`ifdef UART_PKT_CHECKSUM_EN
         sum_q       <= 8'h00;
         err_chk_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         err_len_q   <= err_len_d;
         err_to_q    <= err_to_d;
         err_ovr_q   <= err_ovr_d;
         pkt_valid_q <= (state_d == S_HOLD);
         pkt_len_q   <= (state_d == S_HOLD) ? len_d : 5'd0;
         if (wr_en) begin
            buf_q[idx_q[3:0]] <= rx_data;
         end
`ifdef UART_PKT_CHECKSUM_EN
         sum_q       <= sum_d;
         err_chk_q   <= err_chk_d;
`endif
      end
   end

   assign pkt_valid   = pkt_valid_q;
   assign pkt_len     = pkt_len_q;
   assign err_len     = err_len_q;
   assign err_timeout = err_to_q;
   assign err_overrun = err_ovr_q;
`ifdef UART_PKT_CHECKSUM_EN
   assign err_chk     = err_chk_q;
`else
   assign err_chk     = 1'b0;
`endif

   assign rd_data = ({28'd0, rd_addr} < MAX_LEN) ? buf_q[rd_addr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
`timescale 1ns/1ps
// tb_uart_rx_pkt_ctrl
// Purpose     : directed bench with a packet scoreboard for uart_rx_pkt_ctrl.
// Latency     : inputs driven on falling edges, outputs sampled on falling edges.
// Backpressure: n/a.
module tb_uart_rx_pkt_ctrl;

   localparam int MAXL = 16;
   localparam int TO   = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       pkt_valid;
   logic       pkt_ack;
   logic [4:0] pkt_len;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       err_len, err_chk, err_timeout, err_overrun;

   uart_rx_pkt_ctrl #(.MAX_LEN(MAXL), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
      .pkt_valid(pkt_valid), .pkt_ack(pkt_ack), .pkt_len(pkt_len),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .err_len(err_len), .err_chk(err_chk), .err_timeout(err_timeout), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         len;
      logic [7:0] b [16];
   } pkt_t;

   pkt_t       sb_q [$];
   pkt_t       exp_p;
   logic [7:0] pl [16];

   int checks = 0;
   int errors = 0;
   int n_len = 0, n_chk = 0, n_to = 0, n_ovr = 0, n_multi = 0;
   int base;

   // Error pulse counters; counters are read by the main sequence 1 ns after a falling edge.
   always @(negedge clk) begin
      if (err_len === 1'b1)     n_len++;
      if (err_chk === 1'b1)     n_chk++;
      if (err_timeout === 1'b1) n_to++;
      if (err_overrun === 1'b1) n_ovr++;
      if ((int'(err_len === 1'b1) + int'(err_chk === 1'b1) +
           int'(err_timeout === 1'b1) + int'(err_overrun === 1'b1)) > 1) n_multi++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends SYNC, LEN, pl[0..len-1] and, in checksum builds, the two's-complement checksum.
   task automatic send_frame(input int len, input bit expect_ok);
      logic [7:0] s;
      pkt_t       e;
      send_byte(8'hA5);
      send_byte(8'(len));
      s = 8'(len);
      for (int i = 0; i < len; i++) begin
         send_byte(pl[i]);
         s = s + pl[i];
      end
`ifdef UART_PKT_CHECKSUM_EN
      send_byte(8'h00 - s);
`endif
      if (expect_ok) begin
         e.len = len;
         e.b   = pl;
         sb_q.push_back(e);
      end
   endtask

   // Compares the held packet with the scoreboard head without popping it.
   task automatic check_pkt(input string tag);
      int   n;
      pkt_t e;
      n = 0;
      while ((pkt_valid !== 1'b1) && (n < 50)) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 32'(pkt_valid), 32'd1);
      if (sb_q.size() == 0) begin
         check({tag, "_sb_nonempty"}, 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q[0];
         check({tag, "_len"}, 32'(pkt_len), 32'(e.len));
         for (int i = 0; i < e.len; i++) begin
            rd_addr = 4'(i);
            @(negedge clk);
            check($sformatf("%s_rd%0d", tag, i), 32'(rd_data), 32'(e.b[i]));
         end
      end
   endtask

   task automatic ack(input string tag);
      pkt_ack = 1'b1;
      @(negedge clk);
      pkt_ack = 1'b0;
      check({tag, "_ack_clr"}, 32'(pkt_valid), 32'd0);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
   endtask

   initial begin
      rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; pkt_ack = 1'b0; rd_addr = 4'd0;
      for (int i = 0; i < 16; i++) pl[i] = 8'h00;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_valid", 32'(pkt_valid), 32'd0);
      check("rst_len",   32'(pkt_len),   32'd0);
      check("rst_errs",  32'({err_len, err_chk, err_timeout, err_overrun}), 32'd0);
      check("rst_rd0",   32'(rd_data),   32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 1: basic frame, valid one clk after the last strobe, release, buffer retained
      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      send_frame(3, 1'b1);
      check("t1_valid_lat", 32'(pkt_valid), 32'd1);
      check_pkt("t1");
      ack("t1");
      rd_addr = 4'd0;
      #1;
      check("t1_keep", 32'(rd_data), 32'h11);

      // 2: noise ignored in IDLE, 1-byte frame
      send_byte(8'h00);
      send_byte(8'hFF);
      pl[0] = 8'h5A;
      send_frame(1, 1'b1);
      check_pkt("t2");
      ack("t2");

      // 3: LEN=0 and LEN=MAX_LEN+1 rejected, LEN=MAX_LEN accepted
      send_byte(8'hA5);
      send_byte(8'h00);
      check("t3_len0_pulse", 32'(err_len), 32'd1);
      check("t3_len0_novld", 32'(pkt_valid), 32'd0);
      @(negedge clk);
      check("t3_len0_one", 32'(err_len), 32'd0);
      send_byte(8'hA5);
      send_byte(8'h11);
      check("t3_len17_pulse", 32'(err_len), 32'd1);
      for (int i = 0; i < 16; i++) pl[i] = 8'((i * 8'h13) + 8'h07);
      send_frame(16, 1'b1);
      check_pkt("t3_max");
      ack("t3_max");

      // 4: checksum failure then recovery (or, without checksum, plain 2-byte frame)
`ifdef UART_PKT_CHECKSUM_EN
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h00);
      check("t4_chk_pulse", 32'(err_chk), 32'd1);
      @(negedge clk);
      check("t4_chk_one", 32'(err_chk), 32'd0);
`endif
      pl[0] = 8'h10; pl[1] = 8'h20;
      send_frame(2, 1'b1);
      check("t4_valid_lat", 32'(pkt_valid), 32'd1);
      check_pkt("t4");
      ack("t4");

      // 5: inter-byte timeout fires after TO idle clocks, strobe at expiry wins
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      idle(TO - 1);
      check("t5_to_early", 32'(err_timeout), 32'd0);
      idle(1);
      check("t5_to_pulse", 32'(err_timeout), 32'd1);
      idle(1);
      check("t5_to_one", 32'(err_timeout), 32'd0);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
      idle(TO - 1);
      send_byte(8'h20);
`ifdef UART_PKT_CHECKSUM_EN
      send_byte(8'hCE);
`endif
      exp_p.len = 2;
      exp_p.b   = pl;
      exp_p.b[0] = 8'h10; exp_p.b[1] = 8'h20;
      sb_q.push_back(exp_p);
      check_pkt("t5_expiry");
      #1;
      check("t5_to_count", 32'(n_to), 32'd1);
      // No gap counting while a packet is held
      idle(3 * TO);
      #1;
      check("t5_hold_noto", 32'(n_to), 32'd1);
      check("t5_hold_vld", 32'(pkt_valid), 32'd1);

      // 6: overrun while held, buffer frozen, drop together with release
      base = n_ovr;
      send_byte(8'h99); send_byte(8'h98); send_byte(8'h97);
      #1;
      check("t6_ovr3", 32'(n_ovr - base), 32'd3);
      check_pkt("t6_frozen");
      rx_data = 8'h77; rx_ready = 1'b1; pkt_ack = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0; pkt_ack = 1'b0;
      check("t6_both_ovr", 32'(err_overrun), 32'd1);
      check("t6_both_rel", 32'(pkt_valid), 32'd0);
      if (sb_q.size() > 0) void'(sb_q.pop_front());

      // 7: reset mid-payload aborts silently and clears the buffer
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      rd_addr = 4'd0;
      rst_n   = 1'b0;
      @(negedge clk);
      check("t7_rst_vld", 32'(pkt_valid), 32'd0);
      check("t7_rst_errs", 32'({err_len, err_chk, err_timeout, err_overrun}), 32'd0);
      check("t7_rst_rd0", 32'(rd_data), 32'd0);
      rst_n = 1'b1;
      idle(2 * TO);
      #1;

      // Totals over the whole run
      check("tot_err_len", 32'(n_len), 32'd2);
`ifdef UART_PKT_CHECKSUM_EN
      check("tot_err_chk", 32'(n_chk), 32'd1);
`else
      check("tot_err_chk", 32'(n_chk), 32'd0);
`endif
      check("tot_err_to",  32'(n_to),  32'd1);
      check("tot_err_ovr", 32'(n_ovr), 32'd4);
      check("tot_excl",    32'(n_multi), 32'd0);
      check("tot_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
